// File: rtl/string_accel_avalon.sv
// Avalon-MM string coprocessor: CPU fills a byte buffer, then runs STRLEN, TOUPPER
// or COUNT_CHAR over it one byte per cycle and collects the result by polling or IRQ.
module string_accel_avalon #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int unsigned FW = AW + 1;

  localparam logic [2:0] A_CTRL    = 3'd0;
  localparam logic [2:0] A_STATUS  = 3'd1;
  localparam logic [2:0] A_CHAR    = 3'd2;
  localparam logic [2:0] A_RESULT  = 3'd3;
  localparam logic [2:0] A_BUFDATA = 3'd4;

  localparam logic [1:0] OP_STRLEN  = 2'd0;
  localparam logic [1:0] OP_TOUPPER = 2'd1;
  localparam logic [1:0] OP_COUNT   = 2'd2;
  localparam logic [1:0] OP_NOP     = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t        state, state_d;
  logic [7:0]    buf_mem [DEPTH];
  logic [FW-1:0] fill;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] idx;
  logic [FW-1:0] result;
  logic [1:0]    op;
  logic [7:0]    char_reg;
  logic          irq_en;
  logic          done;
  logic          overflow;

  logic          idle, busy;
  logic          wr_ctrl, wr_status, wr_char, wr_buf, rd_buf;
  logic          start_acc, clear_acc;
  logic [FW-1:0] fill_start;
  logic [7:0]    cur_byte;
  logic          is_lower, last, term, hit;
  logic          done_set, result_inc;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [7:0]    buf_wdata;
  logic          done_d, irq_en_d, irq_d;
  logic [31:0]   rd_mux;

  assign idle      = (state == S_IDLE);
  assign busy      = ~idle;
  assign wr_ctrl   = chipselect & write & (address == A_CTRL);
  assign wr_status = chipselect & write & (address == A_STATUS);
  assign wr_char   = chipselect & write & (address == A_CHAR);
  assign wr_buf    = chipselect & write & (address == A_BUFDATA) & idle;
  assign rd_buf    = chipselect & read  & (address == A_BUFDATA) & idle;
  assign start_acc = wr_ctrl & writedata[0] & idle;
  assign clear_acc = wr_ctrl & writedata[3] & idle;
  // Clear lands before a simultaneous start, so the start sees an empty buffer
  assign fill_start = clear_acc ? '0 : fill;

  assign cur_byte = buf_mem[idx];
  assign is_lower = (cur_byte >= 8'h61) && (cur_byte <= 8'h7A);
  assign last     = ({1'b0, idx} == (fill - FW'(1)));
  assign term     = (op == OP_STRLEN) && (cur_byte == 8'h00);

  always_comb begin
    hit = 1'b0;
    case (op)
      OP_STRLEN:  hit = (cur_byte != 8'h00);
      OP_TOUPPER: hit = is_lower;
      OP_COUNT:   hit = (cur_byte == char_reg);
      default:    hit = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  // Next state; the STRLEN terminator cycle doubles as the finishing cycle
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (start_acc) begin
          if ((fill_start == '0) || (writedata[2:1] == OP_NOP)) state_d = S_FIN;
          else                                                  state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (term)      state_d = S_IDLE;
        else if (last) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: completion, buffer write port and next values of done/irq
  always_comb begin
    done_set   = 1'b0;
    result_inc = 1'b0;
    buf_we     = 1'b0;
    buf_waddr  = fill[AW-1:0];
    buf_wdata  = writedata[7:0];
    case (state)
      S_IDLE: begin
        buf_we = wr_buf && (fill != FW'(DEPTH));
      end
      S_RUN: begin
        result_inc = hit;
        done_set   = term;
        if ((op == OP_TOUPPER) && is_lower) begin
          buf_we    = 1'b1;
          buf_waddr = idx;
          buf_wdata = cur_byte - 8'h20;
        end
      end
      S_FIN:   done_set = 1'b1;
      default: ;
    endcase

    done_d = done;
    if (wr_status && writedata[1]) done_d = 1'b0;
    if (start_acc)                 done_d = 1'b0;
    if (done_set)                  done_d = 1'b1;
    irq_en_d = wr_ctrl ? writedata[4] : irq_en;
    irq_d    = done_d & irq_en_d;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      A_CTRL:    rd_mux = {27'b0, irq_en, 1'b0, op, 1'b0};
      A_STATUS:  rd_mux = {16'b0, 8'(fill), 5'b0, overflow, done, busy};
      A_CHAR:    rd_mux = {24'b0, char_reg};
      A_RESULT:  rd_mux = 32'(result);
      A_BUFDATA: rd_mux = (idle && (fill != '0)) ? {24'b0, buf_mem[rd_ptr]} : 32'b0;
      default:   rd_mux = '0;
    endcase
  end

  // Buffer storage has no reset
  always_ff @(posedge clk) begin
    if (reset_n && buf_we) buf_mem[buf_waddr] <= buf_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
      done     <= 1'b0;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
      fill     <= '0;
      rd_ptr   <= '0;
      idx      <= '0;
      result   <= '0;
      op       <= OP_STRLEN;
      char_reg <= '0;
    end else begin
      readdata <= (chipselect && read) ? rd_mux : 32'b0;
      irq      <= irq_d;
      done     <= done_d;
      irq_en   <= irq_en_d;
      if (wr_char) char_reg <= writedata[7:0];

      if (clear_acc)                       overflow <= 1'b0;
      else if (wr_buf && (fill == FW'(DEPTH))) overflow <= 1'b1;
      else if (wr_status && writedata[2])  overflow <= 1'b0;

      if (clear_acc)                            fill <= '0;
      else if (wr_buf && (fill != FW'(DEPTH)))  fill <= fill + FW'(1);

      // Read pointer parks on the last valid byte
      if (clear_acc || start_acc)
        rd_ptr <= '0;
      else if (rd_buf && (fill != '0) && (({1'b0, rd_ptr} + FW'(1)) < fill))
        rd_ptr <= rd_ptr + AW'(1);

      if (start_acc) begin
        op     <= writedata[2:1];
        idx    <= '0;
        result <= '0;
      end else if (state == S_RUN) begin
        idx <= idx + AW'(1);
        if (result_inc) result <= result + FW'(1);
      end
    end
  end

endmodule

// File: tb/tb_string_accel_avalon.sv
// Directed bench for string_accel_avalon; read expectations flow through a scoreboard queue.
module tb_string_accel_avalon;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  string_accel_avalon #(.DEPTH(64), .AW(6)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  // Push expectation with the request, pop and compare when readdata is valid
  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick();
    chipselect = 1'b0; read = 1'b0;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, readdata, e);
  endtask

  // Polls STATUS every cycle; latency counts cycles from the start write
  task automatic wait_done(input int exp_lat, input int pre, input string tag);
    int n;
    logic seen;
    n = pre;
    seen = 1'b0;
    while (!seen && n < 400) begin
      chipselect = 1'b1; read = 1'b1; address = 3'd1;
      tick();
      chipselect = 1'b0; read = 1'b0;
      n++;
      seen = readdata[1];
    end
    check(tag, 32'(n), 32'(exp_lat));
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    tick();
    bus_read(3'd1, 32'h0, "reset_status");
    bus_read(3'd0, 32'h0, "reset_ctrl");
    bus_read(3'd2, 32'h0, "reset_char");
    bus_read(3'd3, 32'h0, "reset_result");
    bus_read(3'd4, 32'h0, "empty_bufread");

    // 1: STRLEN "hello"
    bus_write(3'd4, 32'h68); bus_write(3'd4, 32'h65); bus_write(3'd4, 32'h6c);
    bus_write(3'd4, 32'h6c); bus_write(3'd4, 32'h6f);
    bus_read(3'd1, 32'h0500, "t1_fill");
    bus_write(3'd0, 32'h01);
    wait_done(7, 0, "t1_latency");
    bus_read(3'd3, 32'd5, "t1_result");
    check("t1_irq", 32'(irq), 32'h0);
    bus_read(3'd1, 32'h0502, "t1_status");

    // 2: TOUPPER with irq
    bus_write(3'd0, 32'h08);
    bus_write(3'd4, 32'h61); bus_write(3'd4, 32'h5A);
    bus_write(3'd4, 32'h7B); bus_write(3'd4, 32'h62);
    bus_write(3'd0, 32'h13);
    wait_done(6, 0, "t2_latency");
    check("t2_irq_set", 32'(irq), 32'h1);
    bus_read(3'd3, 32'd2, "t2_result");
    bus_read(3'd0, 32'h12, "t2_ctrl");
    bus_read(3'd4, 32'h41, "t2_byte0");
    bus_read(3'd4, 32'h5A, "t2_byte1");
    bus_read(3'd4, 32'h7B, "t2_byte2");
    bus_read(3'd4, 32'h42, "t2_byte3");
    bus_read(3'd4, 32'h42, "t2_reread_last");
    bus_write(3'd1, 32'h2);
    check("t2_irq_clear", 32'(irq), 32'h0);
    bus_read(3'd1, 32'h0400, "t2_status_clear");

    // 3: STRLEN stops at terminator, COUNT_CHAR counts zeros
    bus_write(3'd0, 32'h08);
    bus_write(3'd4, 32'h61); bus_write(3'd4, 32'h62); bus_write(3'd4, 32'h00);
    bus_write(3'd4, 32'h63); bus_write(3'd4, 32'h64);
    bus_write(3'd0, 32'h01);
    wait_done(4, 0, "t3_strlen_latency");
    bus_read(3'd3, 32'd2, "t3_strlen_result");
    bus_write(3'd2, 32'h00);
    bus_write(3'd0, 32'h05);
    wait_done(7, 0, "t3_count_latency");
    bus_read(3'd3, 32'd1, "t3_count_zero");

    // 4: overflow and full-buffer count
    bus_write(3'd0, 32'h08);
    bus_write(3'd1, 32'h2);
    for (int i = 0; i < 64; i++) bus_write(3'd4, 32'h78);
    bus_write(3'd4, 32'h79);
    bus_read(3'd1, 32'h4004, "t4_full_overflow");
    for (int i = 0; i < 65; i++) bus_read(3'd4, 32'h78, "t4_readback");
    bus_write(3'd2, 32'h78);
    bus_read(3'd2, 32'h78, "t4_char");
    bus_write(3'd0, 32'h05);
    wait_done(66, 0, "t4_latency");
    bus_read(3'd3, 32'd64, "t4_result");
    bus_write(3'd1, 32'h4);
    bus_read(3'd1, 32'h4002, "t4_overflow_clear");

    // 5: start and BUFDATA traffic while busy are ignored
    bus_write(3'd0, 32'h03);
    bus_write(3'd0, 32'h05);
    bus_write(3'd4, 32'h61);
    bus_read(3'd4, 32'h0, "t5_busy_bufread");
    wait_done(66, 3, "t5_latency");
    bus_read(3'd3, 32'd64, "t5_result");
    bus_read(3'd1, 32'h4002, "t5_status");
    bus_read(3'd4, 32'h58, "t5_upper_byte0");
    bus_write(3'd0, 32'h09);
    wait_done(2, 0, "t5_clear_start_latency");
    bus_read(3'd3, 32'd0, "t5_clear_start_result");
    bus_read(3'd1, 32'h0002, "t5_clear_status");
    bus_read(3'd4, 32'h0, "t5_empty_bufread");
    bus_write(3'd4, 32'h41);
    bus_write(3'd0, 32'h07);
    wait_done(2, 0, "t5_nop_latency");
    bus_read(3'd3, 32'd0, "t5_nop_result");
    bus_read(3'd0, 32'h06, "t5_nop_ctrl");

    // 6: reset mid-TOUPPER
    bus_write(3'd0, 32'h08);
    for (int i = 0; i < 8; i++) bus_write(3'd4, 32'h61);
    bus_write(3'd0, 32'h13);
    tick(); tick();
    reset_n = 1'b0;
    chipselect = 1'b1; read = 1'b1; address = 3'd1;
    tick();
    chipselect = 1'b0; read = 1'b0;
    check("t6_reset_readdata", readdata, 32'h0);
    check("t6_reset_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    bus_read(3'd1, 32'h0, "t6_status");
    bus_read(3'd0, 32'h0, "t6_ctrl");
    bus_read(3'd3, 32'h0, "t6_result");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
